color_decode: RTL and testbench
===============================

# color_decode

Pixel-stream receiver that inverts the palette stage: it samples the 2-bit-per-channel RGB bus plus sync, tracks raster position, and recovers the 4-bit VIC color index for every active pixel. Decoded pixels go into a small first-word-fall-through FIFO drained over a valid/ready handshake. Used for loopback self-test and video capture behind the palette output.

## Interface
Parameters:
- FIFO_DEPTH, 8, entry count; power of two, minimum 2
- X_WIDTH, 10, x counter width
- Y_WIDTH, 9, y counter width

Ports:
- clk_dot4x  in  1  sole clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  sample strobe; inputs below are sampled only when high
- hsync  in  1  active-high horizontal sync
- vsync  in  1  active-high vertical sync
- red, green, blue  in  2 each  palette output levels
- out_valid  out  1  FIFO head holds a pixel
- out_ready  in  1  consumer accepts head this cycle
- out_x  out  X_WIDTH  head pixel x
- out_y  out  Y_WIDTH  head pixel y
- out_color  out  4  recovered index (0 BLACK … 15 LIGHT_GREY, VIC order)
- out_ambig  out  1  triple maps to more than one index
- out_unmapped  out  1  triple not in palette
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky: a pixel was dropped
- frame_start  out  1  one-cycle pulse on sampled vsync rising edge

## Operation
- Stage 1 (pix_en=1): register hsync, vsync, RGB; keep previous sync for edge detection.
- hsync rising edge: x←0, y←y+1 (saturating at all-ones). vsync rising edge: y←0, x←0, frame_start=1; takes priority over hsync edge in the same sample.
- Otherwise each pix_en increments x, saturating at all-ones.
- Active pixel: sampled hsync=0 and vsync=0; only active pixels are decoded and pushed. Pixel x/y are the counter values before increment.
- Stage 2 decode table (r,g,b→index): 333→1, 200→2, 233→3, 313→4, 031→5, 002→6, 331→7, 321→8, 110→9, 311→10, 111→12, 231→13, 023→14, 222→15, 000→0 with ambig=1 (BLACK/DARK_GREY collide). Index 11 never produced.
- Any other triple: handled per Configuration; unmapped=1.
- FIFO: push on stage-2 valid; pop when out_valid && out_ready. Push when full and no pop: pixel dropped, overflow←1 until rst. Push and pop in the same cycle while full: both occur, no drop. Pop when empty: ignored.
- out_* data is don't-care while out_valid=0; it holds stable while out_valid=1 and out_ready=0.

## Timing
- Reset: all outputs 0; counters 0; FIFO empty; sync history 0 (so sync high at first sample counts as a rising edge).
- Latency: pixel sampled on edge N is at FIFO head, out_valid=1, after edge N+2 when FIFO was empty.
- frame_start asserts the cycle after the sampling edge, one cycle wide.
- fifo_level updates the cycle after push/pop; throughput one pixel per cycle with out_ready held high.
- rst mid-frame: FIFO contents and in-flight stage-1/2 pixels discarded immediately.

## Configuration
- COLOR_DECODE_NEAREST_EN defined: unmapped triple → index with minimum |dr|+|dg|+|db| over the 15 table entries, ties to lowest index; out_unmapped=1, out_ambig=0. Combinational search must still meet single-cycle stage 2.
- Undefined: unmapped triple → out_color=0, out_unmapped=1.

## Test plan
- Reset, then vsync pulse, hsync low, RGB=2,0,0 on three strobes → three pushes (x=0..2, y=0, color=2), out_valid 2 cycles after first sample, frame_start one pulse.
- Sweep all 15 table triples → indices per table; 000 gives color 0, ambig=1; 11 never seen.
- RGB=1,0,1: with COLOR_DECODE_NEAREST_EN → color 12, unmapped=1; without → color 0, unmapped=1.
- out_ready=0, FIFO_DEPTH+3 active pixels → fifo_level=8, overflow=1, head still first pixel (x=0); later drain yields exactly 8 pixels in order.
- Full FIFO, out_ready=1 with continuous pushes → no drop, overflow stays 0, level stays 8.
- hsync and vsync rise on same sample after y=5 → y=0, x=0; hsync-only edge next line → y=1; reset asserted mid-line → out_valid=0, fifo_level=0 same cycle.

Source files
------------

// File: rtl/color_decode.sv
// Pixel-stream receiver: tracks raster position, recovers VIC colour indices from 2-bit RGB, queues them in a FWFT FIFO.
// Optional COLOR_DECODE_NEAREST_EN maps off-palette triples to the nearest palette entry instead of index 0.
module color_decode #(
  parameter int FIFO_DEPTH = 8,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9
) (
  input  logic                        clk_dot4x,
  input  logic                        rst,
  input  logic                        pix_en,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic [1:0]                  red,
  input  logic [1:0]                  green,
  input  logic [1:0]                  blue,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [X_WIDTH-1:0]          out_x,
  output logic [Y_WIDTH-1:0]          out_y,
  output logic [3:0]                  out_color,
  output logic                        out_ambig,
  output logic                        out_unmapped,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        frame_start
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = X_WIDTH + Y_WIDTH + 6;

  // Palette levels per VIC index as {r,g,b}; 0 and 11 share the all-zero triple but 11 is never searched.
  function automatic logic [5:0] pal_rgb(input logic [3:0] k);
    case (k)
      4'd1:    return 6'b11_11_11;
      4'd2:    return 6'b10_00_00;
      4'd3:    return 6'b10_11_11;
      4'd4:    return 6'b11_01_11;
      4'd5:    return 6'b00_11_01;
      4'd6:    return 6'b00_00_10;
      4'd7:    return 6'b11_11_01;
      4'd8:    return 6'b11_10_01;
      4'd9:    return 6'b01_01_00;
      4'd10:   return 6'b11_01_01;
      4'd12:   return 6'b01_01_01;
      4'd13:   return 6'b10_11_01;
      4'd14:   return 6'b00_10_11;
      4'd15:   return 6'b10_10_10;
      default: return 6'b00_00_00;
    endcase
  endfunction

  logic                r_hs_prev, r_vs_prev, r_frame_start;
  logic [X_WIDTH-1:0]  r_x, r_s1_x, r_s2_x;
  logic [Y_WIDTH-1:0]  r_y, r_s1_y, r_s2_y;
  logic [5:0]          r_s1_rgb;
  logic                r_s1_valid, r_s2_valid;
  logic [3:0]          r_s2_color;
  logic                r_s2_ambig, r_s2_unmapped;
  logic [3:0]          w_color;
  logic                w_ambig, w_unmapped;
  logic                w_hs_rise, w_vs_rise;

  assign w_hs_rise = hsync & ~r_hs_prev;
  assign w_vs_rise = vsync & ~r_vs_prev;

  // Stage 1: sample inputs, run raster counters, tag pixel with pre-increment position.
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_hs_prev     <= 1'b0;
      r_vs_prev     <= 1'b0;
      r_frame_start <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_s1_x        <= '0;
      r_s1_y        <= '0;
      r_s1_rgb      <= '0;
      r_s1_valid    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_s1_valid    <= 1'b0;
      if (pix_en) begin
        r_hs_prev  <= hsync;
        r_vs_prev  <= vsync;
        r_s1_rgb   <= {red, green, blue};
        r_s1_x     <= r_x;
        r_s1_y     <= r_y;
        r_s1_valid <= ~hsync & ~vsync;
        if (w_vs_rise) begin
          r_x           <= '0;
          r_y           <= '0;
          r_frame_start <= 1'b1;
        end else if (w_hs_rise) begin
          r_x <= '0;
          if (r_y != '1) r_y <= r_y + 1'b1;
        end else if (r_x != '1) begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

`ifdef COLOR_DECODE_NEAREST_EN
  function automatic logic [1:0] adiff(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [3:0] dist(input logic [5:0] a, input logic [5:0] b);
    return 4'(adiff(a[5:4], b[5:4])) + 4'(adiff(a[3:2], b[3:2])) + 4'(adiff(a[1:0], b[1:0]));
  endfunction

  logic [3:0] w_best_d;
`endif

  always_comb begin
    w_color    = 4'd0;
    w_ambig    = 1'b0;
    w_unmapped = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k != 11 && pal_rgb(4'(k)) == r_s1_rgb) begin
        w_color    = 4'(k);
        w_unmapped = 1'b0;
        w_ambig    = (k == 0);
      end
    end
`ifdef COLOR_DECODE_NEAREST_EN
    // Strict less-than with ascending index resolves ties toward the lowest index.
    w_best_d = 4'hF;
    if (w_unmapped) begin
      for (int k = 0; k < 16; k++) begin
        if (k != 11 && dist(pal_rgb(4'(k)), r_s1_rgb) < w_best_d) begin
          w_best_d = dist(pal_rgb(4'(k)), r_s1_rgb);
          w_color  = 4'(k);
        end
      end
    end
`endif
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_s2_x        <= '0;
      r_s2_y        <= '0;
      r_s2_color    <= '0;
      r_s2_ambig    <= 1'b0;
      r_s2_unmapped <= 1'b0;
    end else begin
      r_s2_valid    <= r_s1_valid;
      r_s2_x        <= r_s1_x;
      r_s2_y        <= r_s1_y;
      r_s2_color    <= w_color;
      r_s2_ambig    <= w_ambig;
      r_s2_unmapped <= w_unmapped;
    end
  end

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_full, w_pop, w_push;

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) && out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts when draining.
  assign w_push = r_s2_valid && (!w_full || w_pop);

  always_ff @(posedge clk_dot4x) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_s2_x, r_s2_y, r_s2_color, r_s2_ambig, r_s2_unmapped};
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_s2_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign out_valid   = (r_count != '0);
  assign fifo_level  = r_count;
  assign overflow    = r_overflow;
  assign frame_start = r_frame_start;
  assign {out_x, out_y, out_color, out_ambig, out_unmapped} = out_valid ? r_mem[r_rd_ptr] : '0;
endmodule

// File: tb/tb_color_decode.sv
// Directed bench for color_decode: a raster model predicts each pixel into a scoreboard queue, popped on handshakes.
module tb_color_decode;
  logic       clk = 1'b0;
  logic       rst, pix_en, hsync, vsync, out_ready;
  logic [1:0] red, green, blue;
  logic       out_valid, out_ambig, out_unmapped, overflow, frame_start;
  logic [9:0] out_x;
  logic [8:0] out_y;
  logic [3:0] out_color;
  logic [3:0] fifo_level;

  color_decode #(.FIFO_DEPTH(8), .X_WIDTH(10), .Y_WIDTH(9)) dut (
    .clk_dot4x(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_color(out_color),
    .out_ambig(out_ambig), .out_unmapped(out_unmapped),
    .fifo_level(fifo_level), .overflow(overflow), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] c;
    logic       a;
    logic       u;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_pops = 0;
  int   m_x, m_y;
  logic m_hp, m_vp;
  int   pops_before;

  logic [5:0] sweep [16] = '{6'b111111, 6'b100000, 6'b101111, 6'b110111, 6'b001101,
                             6'b000010, 6'b111101, 6'b111001, 6'b010100, 6'b110101,
                             6'b010101, 6'b101101, 6'b001011, 6'b101010, 6'b000000,
                             6'b010001};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected {color, ambig, unmapped} for a sampled {r,g,b} triple.
  function automatic logic [5:0] expect_of(input logic [5:0] rgb);
    case (rgb)
      6'b111111: return {4'd1,  2'b00};
      6'b100000: return {4'd2,  2'b00};
      6'b101111: return {4'd3,  2'b00};
      6'b110111: return {4'd4,  2'b00};
      6'b001101: return {4'd5,  2'b00};
      6'b000010: return {4'd6,  2'b00};
      6'b111101: return {4'd7,  2'b00};
      6'b111001: return {4'd8,  2'b00};
      6'b010100: return {4'd9,  2'b00};
      6'b110101: return {4'd10, 2'b00};
      6'b010101: return {4'd12, 2'b00};
      6'b101101: return {4'd13, 2'b00};
      6'b001011: return {4'd14, 2'b00};
      6'b101010: return {4'd15, 2'b00};
      6'b000000: return {4'd0,  2'b10};
      6'b010001: begin
`ifdef COLOR_DECODE_NEAREST_EN
        return {4'd12, 2'b01};
`else
        return {4'd0,  2'b01};
`endif
      end
      default:   return {4'd0,  2'b01};
    endcase
  endfunction

  // Drive one strobed sample; it is taken on the following rising edge.
  task automatic pix(input logic h, input logic v, input logic [5:0] rgb, input logic acc);
    exp_t       e;
    logic [5:0] ex;
    @(posedge clk); #1;
    pix_en = 1'b1;
    hsync  = h;
    vsync  = v;
    {red, green, blue} = rgb;
    if (v && !m_vp) begin
      m_x = 0;
      m_y = 0;
    end else if (h && !m_hp) begin
      m_x = 0;
      if (m_y < 511) m_y = m_y + 1;
    end else begin
      if (!h && !v && acc) begin
        ex  = expect_of(rgb);
        e.x = 10'(m_x);
        e.y = 9'(m_y);
        e.c = ex[5:2];
        e.a = ex[1];
        e.u = ex[0];
        q.push_back(e);
      end
      if (m_x < 1023) m_x = m_x + 1;
    end
    m_hp = h;
    m_vp = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_en = 1'b0;
    end
  endtask

  task automatic wait_drain();
    out_ready = 1'b1;
    idle(3);
    for (int i = 0; i < 200; i++) begin
      if (fifo_level == 0 && q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_sb_empty", 32'(q.size()), 0);
    check("drain_level", 32'(fifo_level), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      check("sb_nonempty", 32'(q.size() != 0), 1);
      check("color_not_11", 32'(out_color == 4'd11), 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_pops = n_pops + 1;
        $display("pop x=%0d y=%0d color=%0d ambig=%0d unmapped=%0d", out_x, out_y, out_color, out_ambig, out_unmapped);
        check("out_x", 32'(out_x), 32'(e.x));
        check("out_y", 32'(out_y), 32'(e.y));
        check("out_color", 32'(out_color), 32'(e.c));
        check("out_ambig", 32'(out_ambig), 32'(e.a));
        check("out_unmapped", 32'(out_unmapped), 32'(e.u));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
    red = 2'd0; green = 2'd0; blue = 2'd0; out_ready = 1'b0;
    m_x = 0; m_y = 0; m_hp = 1'b0; m_vp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_out_color", 32'(out_color), 0);
    rst = 1'b0;

    // Frame start, first-pixel latency
    out_ready = 1'b1;
    pix(1'b0, 1'b1, 6'b000000, 1'b1);
    pix(1'b0, 1'b0, 6'b100000, 1'b1);
    check("frame_start_high", 32'(frame_start), 1);
    pix(1'b0, 1'b0, 6'b100000, 1'b1);
    check("frame_start_low", 32'(frame_start), 0);
    check("valid_early_1", 32'(out_valid), 0);
    pix(1'b0, 1'b0, 6'b100000, 1'b1);
    check("valid_early_2", 32'(out_valid), 0);
    idle(1);
    check("valid_latency", 32'(out_valid), 1);
    check("first_head_x", 32'(out_x), 0);
    wait_drain();

    // Full palette sweep plus one off-palette triple
    for (int i = 0; i < 16; i++) pix(1'b0, 1'b0, sweep[i], 1'b1);
    wait_drain();

    // Full FIFO with simultaneous push and pop: nothing dropped
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pix(1'b0, 1'b0, sweep[i], 1'b1);
    idle(4);
    check("fill_level", 32'(fifo_level), 8);
    for (int i = 0; i < 8; i++) begin
      pix(1'b0, 1'b0, sweep[i+8], 1'b1);
      if (i == 2) out_ready = 1'b1;
      if (i >= 3) check("full_pp_level", 32'(fifo_level), 8);
    end
    idle(4);
    check("full_pp_no_overflow", 32'(overflow), 0);
    wait_drain();

    // Overflow: three of eleven pixels dropped, head and order preserved
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) pix(1'b0, 1'b0, sweep[i], i < 8);
    idle(4);
    check("ovf_level", 32'(fifo_level), 8);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_head_x", 32'(out_x), 32'(q[0].x));
    pops_before = n_pops;
    wait_drain();
    check("ovf_drain_count", 32'(n_pops - pops_before), 8);
    check("ovf_still_set", 32'(overflow), 1);

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    q.delete();
    m_x = 0; m_y = 0; m_hp = 1'b0; m_vp = 1'b0;
    check("ovf_cleared_by_rst", 32'(overflow), 0);

    // Raster tracking: five lines, then coincident hsync/vsync, then one hsync line
    out_ready = 1'b1;
    pix(1'b0, 1'b1, 6'b000000, 1'b1);
    pix(1'b0, 1'b0, 6'b111111, 1'b1);
    for (int r = 1; r <= 5; r++) begin
      pix(1'b1, 1'b0, 6'b000000, 1'b1);
      pix(1'b0, 1'b0, 6'b100000, 1'b1);
      pix(1'b0, 1'b0, 6'b101111, 1'b1);
    end
    pix(1'b1, 1'b1, 6'b000000, 1'b1);
    pix(1'b0, 1'b0, 6'b110111, 1'b1);
    pix(1'b1, 1'b0, 6'b000000, 1'b1);
    pix(1'b0, 1'b0, 6'b001101, 1'b1);
    check("coincident_sync_frame_start", 32'(m_y), 1);
    wait_drain();

    // Reset mid-line with pixels queued and in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) pix(1'b0, 1'b0, sweep[i], 1'b1);
    idle(2);
    check("pre_rst_nonempty", 32'(fifo_level != 0), 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_fifo_level", 32'(fifo_level), 0);
    q.delete();
    idle(2);
    rst = 1'b0;
    m_x = 0; m_y = 0; m_hp = 1'b0; m_vp = 1'b0;
    idle(5);
    check("post_rst_out_valid", 32'(out_valid), 0);
    check("post_rst_fifo_level", 32'(fifo_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
